// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes, traps and a retire counter
module multicycle_ctrl #(
  parameter int ALUOP_W     = 3,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [6:0]         opcode_i,
  input  logic               mem_ready_i,
  input  logic               trap_clr_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic               ir_write_o,
  output logic               pc_write_o,
  output logic               branch_o,
  output logic               regwrite_o,
  output logic               alusrc_o,
  output logic               memtoreg_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic               trap_o,
  output logic [1:0]         cause_o,
  output logic [CNT_W-1:0]   retire_cnt_o
);
  typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {C_NONE, C_R, C_I, C_L, C_S, C_B, C_J} cls_t;
  localparam int WW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) + 1 : 1;
  state_t           r_state, w_next;
  cls_t             r_cls, w_cls;
  logic [WW-1:0]    r_wait;
  logic [1:0]       r_cause;
  logic [2:0]       w_aluop;
  logic             w_timeout, w_retire, w_waiting;
  assign w_cls = opcode_i == 7'b0110011 ? C_R :
                 opcode_i == 7'b0010011 ? C_I :
                 opcode_i == 7'b0000011 ? C_L :
                 opcode_i == 7'b0100011 ? C_S :
                 opcode_i == 7'b1100011 ? C_B :
                 opcode_i == 7'b1100111 ? C_J : C_NONE;
  assign w_aluop = r_cls == C_I ? 3'd1 : r_cls == C_S ? 3'd2 : r_cls == C_L ? 3'd3 :
                   r_cls == C_B ? 3'd4 : r_cls == C_J ? 3'd5 : 3'd0;
  assign w_waiting = (r_state == S_FETCH || r_state == S_MEM) && !mem_ready_i;
  // r_wait holds completed wait cycles, so the trap fires at the end of the TIMEOUT_CYC-th one
  assign w_timeout = (TIMEOUT_CYC > 0) && w_waiting && r_wait == WW'(TIMEOUT_CYC - 1);
  assign cause_o = r_cause;
  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    ir_write_o = 1'b0;
    pc_write_o = 1'b0;
    branch_o   = 1'b0;
    regwrite_o = 1'b0;
    alusrc_o   = 1'b0;
    memtoreg_o = 1'b0;
    aluop_o    = '0;
    trap_o     = 1'b0;
    case (r_state)
      S_RST: w_next = S_FETCH;
      S_FETCH: begin
        mem_req_o  = 1'b1;
        ir_write_o = mem_ready_i;
        pc_write_o = mem_ready_i;
        w_next     = mem_ready_i ? S_DECODE : w_timeout ? S_TRAP : S_FETCH;
      end
      S_DECODE: w_next = w_cls == C_NONE ? S_TRAP : S_EXEC;
      S_EXEC: begin
        alusrc_o = r_cls == C_I || r_cls == C_S || r_cls == C_L;
        aluop_o  = ALUOP_W'(w_aluop);
        branch_o = r_cls == C_B || r_cls == C_J;
        w_retire = r_cls == C_B;
        w_next   = (r_cls == C_L || r_cls == C_S) ? S_MEM : r_cls == C_B ? S_FETCH : S_WB;
      end
      S_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = r_cls == C_S;
        alusrc_o  = 1'b1;
        aluop_o   = ALUOP_W'(w_aluop);
        w_retire  = mem_ready_i && r_cls == C_S;
        w_next    = mem_ready_i ? (r_cls == C_S ? S_FETCH : S_WB) : w_timeout ? S_TRAP : S_MEM;
      end
      S_WB: begin
        regwrite_o = 1'b1;
        memtoreg_o = r_cls == C_L;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_TRAP: begin
        trap_o = 1'b1;
        w_next = trap_clr_i ? S_FETCH : S_TRAP;
      end
      default: w_next = S_RST;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_RST;
      r_cls        <= C_NONE;
      r_wait       <= '0;
      r_cause      <= 2'b00;
      retire_cnt_o <= '0;
    end else begin
      r_state      <= w_next;
      r_cls        <= r_state == S_DECODE ? w_cls : r_cls;
      r_wait       <= w_next != r_state ? '0 : w_waiting ? r_wait + 1'b1 : r_wait;
      r_cause      <= w_next != S_TRAP ? 2'b00 : r_state == S_DECODE ? 2'b01 :
                      r_state != S_TRAP ? 2'b10 : r_cause;
      retire_cnt_o <= retire_cnt_o + {{(CNT_W-1){1'b0}}, w_retire};
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle vectors checking strobes, traps and retire count
module tb_multicycle_ctrl;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b0, clr = 1'b0;
  logic [6:0]  op = 7'd0;
  logic        mem_req, mem_we, ir_write, pc_write, branch, regwrite, alusrc, memtoreg, trap;
  logic [2:0]  aluop;
  logic [1:0]  cause;
  logic [31:0] cnt;
  logic [13:0] obs;
  int vecs = 0, errs = 0;
  localparam logic [6:0] OP_R = 7'b0110011, OP_L = 7'b0000011, OP_S = 7'b0100011,
                         OP_B = 7'b1100011, OP_X = 7'b1111111;
  multicycle_ctrl #(.ALUOP_W(3), .TIMEOUT_CYC(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(op), .mem_ready_i(rdy), .trap_clr_i(clr),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .branch_o(branch), .regwrite_o(regwrite), .alusrc_o(alusrc), .memtoreg_o(memtoreg),
    .aluop_o(aluop), .trap_o(trap), .cause_o(cause), .retire_cnt_o(cnt)
  );
  always #5 clk = ~clk;
  // {req we ir pc}_{br rw as mt}_{aluop}_{trap cause}
  assign obs = {mem_req, mem_we, ir_write, pc_write, branch, regwrite, alusrc, memtoreg, aluop, trap, cause};
  function automatic logic [22:0] v(input logic r, input logic c, input logic [6:0] o, input logic [13:0] e);
    return {r, c, o, e};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #1 rst = 1'b1;
    tick();
    tick();
    vecs += 2;
    if (obs !== 14'd0) begin errs++; $display("FAIL reset_out got=%b want=0", obs); end
    if (cnt !== 32'd0) begin errs++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
    rst = 1'b0;
    rdy = 1'b1;
    #1;
    vecs++;
    if (obs !== 14'd0) begin errs++; $display("FAIL reset_release got=%b want=0", obs); end
    tick();
  endtask
  task automatic test_rtype;
    logic [22:0] t [4];
    t = '{v(1, 0, OP_R, 14'b1011_0000_000_000), v(0, 0, OP_R, 14'b0000_0000_000_000),
          v(0, 0, OP_R, 14'b0000_0000_000_000), v(0, 0, OP_R, 14'b0000_0100_000_000)};
    foreach (t[i]) begin
      {rdy, clr, op} = t[i][22:14];
      #1;
      vecs++;
      if (obs !== t[i][13:0]) begin errs++; $display("FAIL rtype[%0d] got=%b want=%b", i, obs, t[i][13:0]); end
      tick();
    end
    vecs++;
    if (cnt !== 32'd1) begin errs++; $display("FAIL rtype_cnt got=%0d want=1", cnt); end
  endtask
  task automatic test_load;
    logic [22:0] t [8];
    t = '{v(1, 0, OP_L, 14'b1011_0000_000_000), v(1, 0, OP_L, 14'b0000_0000_000_000),
          v(0, 0, OP_L, 14'b0000_0010_011_000), v(0, 0, OP_L, 14'b1000_0010_011_000),
          v(0, 0, OP_L, 14'b1000_0010_011_000), v(0, 0, OP_L, 14'b1000_0010_011_000),
          v(1, 0, OP_L, 14'b1000_0010_011_000), v(0, 0, OP_L, 14'b0000_0101_000_000)};
    foreach (t[i]) begin
      {rdy, clr, op} = t[i][22:14];
      #1;
      vecs++;
      if (obs !== t[i][13:0]) begin errs++; $display("FAIL load[%0d] got=%b want=%b", i, obs, t[i][13:0]); end
      tick();
    end
    vecs++;
    if (cnt !== 32'd2) begin errs++; $display("FAIL load_cnt got=%0d want=2", cnt); end
  endtask
  task automatic test_back_to_back;
    logic [22:0] t [8];
    t = '{v(1, 0, OP_S, 14'b1011_0000_000_000), v(0, 0, OP_S, 14'b0000_0000_000_000),
          v(0, 0, OP_S, 14'b0000_0010_010_000), v(1, 0, OP_S, 14'b1100_0010_010_000),
          v(1, 0, OP_B, 14'b1011_0000_000_000), v(0, 0, OP_B, 14'b0000_0000_000_000),
          v(1, 0, OP_B, 14'b0000_1000_100_000), v(0, 0, OP_B, 14'b1000_0000_000_000)};
    foreach (t[i]) begin
      {rdy, clr, op} = t[i][22:14];
      #1;
      vecs++;
      if (obs !== t[i][13:0]) begin errs++; $display("FAIL store_branch[%0d] got=%b want=%b", i, obs, t[i][13:0]); end
      tick();
    end
    vecs++;
    if (cnt !== 32'd4) begin errs++; $display("FAIL store_branch_cnt got=%0d want=4", cnt); end
    {rdy, op} = {1'b1, OP_X};
    tick();
  endtask
  task automatic test_illegal;
    logic [22:0] t [4];
    t = '{v(0, 0, OP_X, 14'b0000_0000_000_000), v(0, 0, OP_X, 14'b0000_0000_000_101),
          v(1, 0, OP_X, 14'b0000_0000_000_101), v(0, 1, OP_X, 14'b0000_0000_000_101)};
    foreach (t[i]) begin
      {rdy, clr, op} = t[i][22:14];
      #1;
      vecs++;
      if (obs !== t[i][13:0]) begin errs++; $display("FAIL illegal[%0d] got=%b want=%b", i, obs, t[i][13:0]); end
      tick();
    end
    {rdy, clr} = 2'b00;
    #1;
    vecs += 2;
    if (obs !== 14'b1000_0000_000_000) begin errs++; $display("FAIL illegal_clr got=%b want=%b", obs, 14'b1000_0000_000_000); end
    if (cnt !== 32'd4) begin errs++; $display("FAIL illegal_cnt got=%0d want=4", cnt); end
  endtask
  task automatic test_timeout;
    logic [22:0] t [13];
    t = '{v(0, 0, OP_R, 14'b1000_0000_000_000), v(0, 0, OP_R, 14'b1000_0000_000_000),
          v(0, 0, OP_R, 14'b1000_0000_000_000), v(0, 0, OP_R, 14'b1000_0000_000_000),
          v(0, 0, OP_R, 14'b0000_0000_000_110), v(0, 1, OP_R, 14'b0000_0000_000_110),
          v(0, 0, OP_R, 14'b1000_0000_000_000), v(0, 0, OP_R, 14'b1000_0000_000_000),
          v(0, 0, OP_R, 14'b1000_0000_000_000), v(1, 0, OP_R, 14'b1011_0000_000_000),
          v(0, 0, OP_R, 14'b0000_0000_000_000), v(0, 0, OP_R, 14'b0000_0000_000_000),
          v(0, 0, OP_R, 14'b0000_0100_000_000)};
    foreach (t[i]) begin
      {rdy, clr, op} = t[i][22:14];
      #1;
      vecs++;
      if (obs !== t[i][13:0]) begin errs++; $display("FAIL timeout[%0d] got=%b want=%b", i, obs, t[i][13:0]); end
      tick();
    end
    vecs++;
    if (cnt !== 32'd5) begin errs++; $display("FAIL timeout_cnt got=%0d want=5", cnt); end
  endtask
  task automatic test_reset_mid;
    logic [22:0] t [4];
    t = '{v(1, 0, OP_S, 14'b1011_0000_000_000), v(0, 0, OP_S, 14'b0000_0000_000_000),
          v(0, 0, OP_S, 14'b0000_0010_010_000), v(0, 0, OP_S, 14'b1100_0010_010_000)};
    foreach (t[i]) begin
      {rdy, clr, op} = t[i][22:14];
      #1;
      vecs++;
      if (obs !== t[i][13:0]) begin errs++; $display("FAIL reset_mid[%0d] got=%b want=%b", i, obs, t[i][13:0]); end
      if (i < 3) tick();
    end
    rst = 1'b1;
    #1;
    vecs += 2;
    if (obs !== 14'd0) begin errs++; $display("FAIL reset_mid_out got=%b want=0", obs); end
    if (cnt !== 32'd0) begin errs++; $display("FAIL reset_mid_cnt got=%0d want=0", cnt); end
    tick();
    rst = 1'b0;
    #1;
    vecs++;
    if (obs !== 14'd0) begin errs++; $display("FAIL reset_mid_rst got=%b want=0", obs); end
    tick();
    vecs++;
    if (obs !== 14'b1000_0000_000_000) begin errs++; $display("FAIL reset_mid_fetch got=%b want=%b", obs, 14'b1000_0000_000_000); end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives per-state datapath strobes from a latched opcode class.
- Adds memory ready handshakes, a wait-timeout trap, an illegal-opcode trap and a retired-instruction counter.
- Sits between instruction/data memory and the shared ALU/register-file datapath.

Parameters:
- ALUOP_W, 3, width of aluop_o.
- TIMEOUT_CYC, 16, max wait cycles for mem_ready_i in FETCH or MEM; 0 disables timeout.
- CNT_W, 32, width of retire_cnt_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- opcode_i  in  7  instruction opcode from IR; stable from DECODE onward.
- mem_ready_i  in  1  memory completes current request this cycle.
- trap_clr_i  in  1  leave TRAP, resume at FETCH.
- mem_req_o  out  1  memory request (fetch or data).
- mem_we_o  out  1  data write (stores only).
- ir_write_o  out  1  load IR.
- pc_write_o  out  1  PC <= PC+4.
- branch_o  out  1  branch/jump evaluate-and-update strobe.
- regwrite_o  out  1  register file write.
- alusrc_o  out  1  1 = immediate, 0 = register operand.
- memtoreg_o  out  1  1 = writeback from memory.
- aluop_o  out  ALUOP_W  ALU operation class.
- trap_o  out  1  in TRAP.
- cause_o  out  2  01 illegal opcode, 10 timeout, 00 none.
- retire_cnt_o  out  CNT_W  retired instruction count.

Behaviour:
- Reset (async, rst_i=1):
  - state = RST, class = NONE, wait counter = 0, retire_cnt_o = 0, cause_o = 00.
  - All outputs 0 while in RST.
  - RST -> FETCH on the first clock after rst_i deasserts.
  - rst_i asserted in any state, mid-transaction included, aborts immediately to RST; no pending strobe completes.
- FETCH:
  - mem_req_o = 1.
  - On mem_ready_i = 1: ir_write_o = pc_write_o = 1 in that same cycle (combinational on mem_ready_i), then -> DECODE.
- DECODE:
  - Latch class from opcode_i: 0110011 R, 0010011 I, 0000011 L, 0100011 S, 1100011 B, 1100111 J.
  - Legal opcode -> EXEC. Any other opcode -> TRAP with cause 01.
- EXEC: alusrc_o and aluop_o driven per class:
  - R: alusrc 0, aluop 000.
  - I: alusrc 1, aluop 001.
  - S: alusrc 1, aluop 010.
  - L: alusrc 1, aluop 011.
  - B: alusrc 0, aluop 100.
  - J: alusrc 0, aluop 101.
  - aluop values are zero-extended to ALUOP_W.
  - B and J assert branch_o for exactly this cycle.
  - Next state: R/I/J -> WB; L/S -> MEM; B -> FETCH.
- MEM:
  - mem_req_o = 1; mem_we_o = 1 only for S; alusrc_o and aluop_o held from EXEC.
  - On mem_ready_i: S -> FETCH, L -> WB.
- WB:
  - regwrite_o = 1 for one cycle; memtoreg_o = 1 only for L.
  - Next state: FETCH.
- Retirement:
  - retire_cnt_o increments by 1 on the edge leaving WB, leaving MEM for S, and leaving EXEC for B.
  - At all-ones it wraps to 0.
- Wait counter:
  - Counts cycles in FETCH or MEM with mem_ready_i = 0; clears on every state change.
  - If TIMEOUT_CYC > 0 and the count reaches TIMEOUT_CYC with mem_ready_i still 0 -> TRAP with cause 10.
  - mem_ready_i = 1 on the cycle the count reaches TIMEOUT_CYC wins: the transaction completes and no trap is taken.
- TRAP:
  - trap_o = 1; all strobes 0; cause_o held.
  - trap_clr_i = 1 -> FETCH; cause_o clears to 00 on that transition. retire_cnt_o is not incremented.
- cause_o retains the last trap cause only while in TRAP; 00 elsewhere.
- mem_ready_i is ignored outside FETCH and MEM.
- trap_clr_i is ignored outside TRAP.

Test Plan:
- Reset, then R-type 0110011 with mem_ready_i = 1 on the 1st fetch cycle: FETCH, DECODE, EXEC (aluop 000, alusrc 0), WB (regwrite 1), back to FETCH; retire_cnt_o = 1 after 4 cycles.
- Load 0000011 with data mem_ready_i delayed 3 cycles: mem_req_o held 4 MEM cycles, mem_we_o = 0, then WB with memtoreg_o = 1 and regwrite_o = 1.
- Store 0100011 then branch 1100011: store shows mem_we_o = 1 and no regwrite; branch pulses branch_o for exactly 1 cycle in EXEC; retire_cnt_o advances by 2.
- Opcode 1111111: TRAP entered after DECODE, cause_o = 01, trap_o = 1; pulse trap_clr_i -> next state FETCH, cause_o = 00, count unchanged.
- TIMEOUT_CYC = 4, mem_ready_i held 0 in FETCH: trap_o rises after 4 wait cycles, cause_o = 10. Repeat with mem_ready_i = 1 on the 4th wait cycle: no trap, IR loads.
- Assert rst_i mid-MEM of a store: all outputs 0 immediately, retire_cnt_o = 0, restart at FETCH one cycle after release.
